noc_request_injector: RTL and testbench
=======================================

# noc_request_injector

Parametrised request injector between a local requester client and one NoC input port. Accepts register-read requests through a valid/ready handshake and buffers them in an internal FIFO, so no request is lost. Each request becomes a packet addressed to the owning node and is injected under the NoC's full/almost_full backpressure. Optionally loops node-local requests back without touching the NoC.

## Interface
- ADDR_W, 6, request (register id) width; must be > DEST_W
- ID_W, 2, source node id width
- DEST_W, 2, destination field width; NUM_DEST = 2**DEST_W nodes
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- LOCAL_BYPASS, 0, 1 = requests whose dest equals own id go to local port instead of NoC
- CNT_W, 16, sent-packet counter width
- Derived: PKT_W = ADDR_W+ID_W+DEST_W+1

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id  in  ID_W  own node id, static after reset
- req_valid  in  1  client request present
- req_addr  in  ADDR_W  requested register id
- req_ready  out  1  FIFO can accept (combinational from count)
- full  in  1  NoC input buffer full
- almost_full  in  1  NoC input buffer has one slot left
- data_out  out  PKT_W  packet to NoC
- write  out  1  data_out valid this cycle
- local_valid  out  1  bypass packet valid (LOCAL_BYPASS=1 only, else tied 0)
- local_data  out  PKT_W  bypass packet
- sent_cnt  out  CNT_W  packets injected to NoC, wraps

## Operation
- Reset: data_out, write, local_valid, local_data, sent_cnt = 0. FIFO emptied; req_ready = 1 after reset.
- Packet format, MSB→LSB: {addr[ADDR_W-1:0], src id, dest, valid=1}.
- dest = addr[ADDR_W-1 -: DEST_W], i.e. address space split into NUM_DEST equal ranges. Example, defaults: 0–15→0, 16–31→1, 32–47→2, 48–63→3.
- Accept: push on req_valid && req_ready. req_ready = (count != DEPTH). It does not depend on a same-cycle pop. req_valid while not ready is ignored, and the client holds the request.
- Injection permission: perm = write ? !almost_full : !full. Rationale: a packet written last cycle is not yet reflected in full.
- Each cycle, when the FIFO is non-empty, inspect the head:
  - LOCAL_BYPASS=1 and dest==id: pop; local_valid<=1; local_data<=packet; write<=0. Not subject to perm.
  - Otherwise, if perm: pop; write<=1; data_out<=packet; sent_cnt<=sent_cnt+1 (mod 2**CNT_W).
  - Otherwise: write<=0 and the head stays (stall). data_out holds its last value.
- FIFO empty: write<=0, local_valid<=0.
- At most one pop per cycle. Strict FIFO order across NoC and local outputs; a stalled NoC head blocks following local requests.
- Simultaneous push and pop leaves count unchanged. The FIFO is dual-pointer, with pointers wrapping modulo DEPTH.

## Timing
- All outputs are registered, except req_ready.
- Latency: a request accepted at edge E0 into an empty FIFO gives write=1 (or local_valid=1) after edge E1 (1 cycle), provided perm holds in the E0–E1 cycle.
- write and local_valid are single-cycle pulses per packet. Back-to-back packets assert them continuously.
- Sustained throughput is 1 packet/cycle while !almost_full. With almost_full held, injection alternates 1-on/1-off.
- full/almost_full are sampled in the cycle before the edge that would raise write.
- Reset mid-operation: all buffered requests are discarded, outputs drop to 0 asynchronously, and sent_cnt clears.

## Test plan
- Single request, defaults, id=1, addr=37, NoC idle → one write pulse 1 cycle after accept, data_out = {6'd37,2'd1,2'd2,1'b1}, sent_cnt=1.
- Burst of 6 requests addr 0,16,32,48,5,63 with full=1 → req_ready drops after 4 accepts. Release full → 4 packets in order with dest 0,1,2,3. The client then pushes the remaining 2, and all 6 are delivered with none lost.
- Continuous stream with almost_full=1, full=0 → write pattern 1,0,1,0; no packet dropped or duplicated.
- LOCAL_BYPASS=1, id=2, requests addr 40, 10 → addr 40 appears on local_valid only (write stays 0), then addr 10 goes to the NoC; sent_cnt=1.
- Assert reset with 3 buffered requests and write=1 → write, local_valid, sent_cnt = 0 immediately; after release req_ready=1 and no stale packet is emitted.
- CNT_W=2, inject 5 packets → sent_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/noc_request_injector_if.sv
// Bundle of the client request handshake, the NoC injection port and the
// local bypass port of noc_request_injector. The injector is the slave side.
interface noc_request_injector_if #(
  parameter int ADDR_W = 6,
  parameter int ID_W   = 2,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 16
);
  localparam int PKT_W = ADDR_W + ID_W + DEST_W + 1;

  logic [ID_W-1:0]   id;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              full;
  logic              almost_full;
  logic [PKT_W-1:0]  data_out;
  logic              write;
  logic              local_valid;
  logic [PKT_W-1:0]  local_data;
  logic [CNT_W-1:0]  sent_cnt;

  modport slave (
    input  id, req_valid, req_addr, full, almost_full,
    output req_ready, data_out, write, local_valid, local_data, sent_cnt
  );

  modport master (
    output id, req_valid, req_addr, full, almost_full,
    input  req_ready, data_out, write, local_valid, local_data, sent_cnt
  );
endinterface

// File: rtl/noc_request_injector.sv
// Request injector: buffers client register-read requests in a small FIFO and
// turns each one into a NoC packet {addr, src id, dest, 1}. The destination
// node is the top DEST_W bits of the address. With LOCAL_BYPASS set, packets
// addressed to this node leave on the local port instead of the NoC.
module noc_request_injector #(
  parameter int ADDR_W       = 6,
  parameter int ID_W         = 2,
  parameter int DEST_W       = 2,
  parameter int DEPTH        = 4,
  parameter int LOCAL_BYPASS = 0,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  reset,
  noc_request_injector_if.slave bus
);
  localparam int PKT_W = ADDR_W + ID_W + DEST_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              push;
  logic              pop;
  logic              empty;
  logic              perm;
  logic              head_local;
  logic [ADDR_W-1:0] head_addr;
  logic [DEST_W-1:0] head_dest;
  logic [PKT_W-1:0]  head_pkt;

  logic [PKT_W-1:0]  data_out_q;
  logic              write_q;
  logic              local_valid_q;
  logic [PKT_W-1:0]  local_data_q;
  logic [CNT_W-1:0]  sent_cnt_q;

  // req_ready only looks at occupancy, never at a same-cycle pop, so the
  // client handshake has no combinational path from the NoC backpressure.
  assign bus.req_ready = (count != FULL_CNT);
  assign push          = bus.req_valid && bus.req_ready;
  assign empty         = (count == '0);

  assign head_addr  = mem[rd_ptr];
  assign head_dest  = head_addr[ADDR_W-1 -: DEST_W];
  assign head_pkt   = {head_addr, bus.id, head_dest, 1'b1};
  assign head_local = (LOCAL_BYPASS != 0) && (int'(head_dest) == int'(bus.id));

  // A packet written last cycle is not yet visible in full, so right after a
  // write we must see almost_full low before writing again.
  assign perm = write_q ? !bus.almost_full : !bus.full;
  assign pop  = !empty && (head_local || perm);

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.req_addr;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2**PTR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head dispatch: local bypass, NoC injection, or stall with data_out held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q    <= '0;
      write_q       <= 1'b0;
      local_valid_q <= 1'b0;
      local_data_q  <= '0;
      sent_cnt_q    <= '0;
    end else if (empty) begin
      write_q       <= 1'b0;
      local_valid_q <= 1'b0;
    end else if (head_local) begin
      write_q       <= 1'b0;
      local_valid_q <= 1'b1;
      local_data_q  <= head_pkt;
    end else if (perm) begin
      write_q       <= 1'b1;
      local_valid_q <= 1'b0;
      data_out_q    <= head_pkt;
      sent_cnt_q    <= sent_cnt_q + 1'b1;
    end else begin
      write_q       <= 1'b0;
      local_valid_q <= 1'b0;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.write       = write_q;
  assign bus.local_valid = local_valid_q;
  assign bus.local_data  = local_data_q;
  assign bus.sent_cnt    = sent_cnt_q;
endmodule

// File: tb/tb_noc_request_injector.sv
// Bench for noc_request_injector: a default instance (no bypass, 16-bit
// counter) and a bypass instance with a 2-bit counter share clock and reset.
// Expected packets are queued when a request is accepted and compared when
// the DUT emits them. Inputs change and outputs are sampled on negedge.
module tb_noc_request_injector;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   a_writes = 0;

  logic [10:0] exp_a [$];
  logic [10:0] exp_bn [$];
  logic [10:0] exp_bl [$];
  logic [10:0] mon_a, mon_bn, mon_bl;

  noc_request_injector_if #(.ADDR_W(6), .ID_W(2), .DEST_W(2), .CNT_W(16)) a ();
  noc_request_injector_if #(.ADDR_W(6), .ID_W(2), .DEST_W(2), .CNT_W(2))  b ();

  noc_request_injector #(
    .ADDR_W(6), .ID_W(2), .DEST_W(2), .DEPTH(4), .LOCAL_BYPASS(0), .CNT_W(16)
  ) u_def (
    .clk(clk), .reset(reset), .bus(a.slave)
  );

  noc_request_injector #(
    .ADDR_W(6), .ID_W(2), .DEST_W(2), .DEPTH(4), .LOCAL_BYPASS(1), .CNT_W(2)
  ) u_byp (
    .clk(clk), .reset(reset), .bus(b.slave)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Reference packet: dest is the address quarter the register falls into.
  function automatic logic [10:0] mk_pkt(input logic [5:0] addr, input logic [1:0] src);
    logic [1:0] d;
    d = 2'(addr / 6'd16);
    return {addr, src, d, 1'b1};
  endfunction

  // Scoreboard for NoC writes of the default instance.
  always @(negedge clk) begin
    if (!reset && a.write) begin
      a_writes++;
      n_checks++;
      if (exp_a.size() == 0) begin
        $display("FAIL def_write_unexpected: data_out=%h, expected no packet", a.data_out);
      end else begin
        mon_a = exp_a.pop_front();
        if (a.data_out !== mon_a) $display("FAIL def_write_data: data_out=%h, expected %h", a.data_out, mon_a);
        else n_pass++;
      end
    end
    if (!reset && a.local_valid) begin
      n_checks++;
      $display("FAIL def_local_valid: local_valid=1, expected 0 without bypass");
    end
  end

  // Scoreboard for NoC writes and local packets of the bypass instance.
  always @(negedge clk) begin
    if (!reset && b.write) begin
      n_checks++;
      if (exp_bn.size() == 0) begin
        $display("FAIL byp_write_unexpected: data_out=%h, expected no packet", b.data_out);
      end else begin
        mon_bn = exp_bn.pop_front();
        if (b.data_out !== mon_bn) $display("FAIL byp_write_data: data_out=%h, expected %h", b.data_out, mon_bn);
        else n_pass++;
      end
    end
    if (!reset && b.local_valid) begin
      n_checks++;
      if (exp_bl.size() == 0) begin
        $display("FAIL byp_local_unexpected: local_data=%h, expected no packet", b.local_data);
      end else begin
        mon_bl = exp_bl.pop_front();
        if (b.local_data !== mon_bl) $display("FAIL byp_local_data: local_data=%h, expected %h", b.local_data, mon_bl);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    a.id = 2'd1; a.req_valid = 1'b0; a.req_addr = '0; a.full = 1'b0; a.almost_full = 1'b0;
    b.id = 2'd2; b.req_valid = 1'b0; b.req_addr = '0; b.full = 1'b0; b.almost_full = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a.write !== 1'b0) $display("FAIL reset_write: got %b, expected 0", a.write); else n_pass++;
    n_checks++; if (a.data_out !== 11'd0) $display("FAIL reset_data_out: got %h, expected 0", a.data_out); else n_pass++;
    n_checks++; if (a.sent_cnt !== 16'd0) $display("FAIL reset_sent_cnt: got %0d, expected 0", a.sent_cnt); else n_pass++;
    n_checks++; if (a.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b, expected 1", a.req_ready); else n_pass++;
    n_checks++; if (b.local_valid !== 1'b0 || b.local_data !== 11'd0)
      $display("FAIL reset_local: got valid=%b data=%h, expected 0/0", b.local_valid, b.local_data); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [10:0] want;
    want = {6'd37, 2'd1, 2'd2, 1'b1};
    @(negedge clk);
    a.req_valid = 1'b1; a.req_addr = 6'd37;
    exp_a.push_back(mk_pkt(6'd37, 2'd1));
    @(negedge clk);
    a.req_valid = 1'b0;
    n_checks++; if (a.write !== 1'b0) $display("FAIL single_early_write: got %b, expected 0", a.write); else n_pass++;
    @(negedge clk);
    n_checks++; if (a.write !== 1'b1) $display("FAIL single_latency: write=%b, expected 1", a.write); else n_pass++;
    n_checks++; if (a.data_out !== want) $display("FAIL single_packet: got %h, expected %h", a.data_out, want); else n_pass++;
    n_checks++; if (a.sent_cnt !== 16'd1) $display("FAIL single_sent_cnt: got %0d, expected 1", a.sent_cnt); else n_pass++;
    @(negedge clk);
    n_checks++; if (a.write !== 1'b0) $display("FAIL single_pulse: write=%b, expected 0", a.write); else n_pass++;
  endtask

  task automatic test_burst();
    logic [5:0] addrs [6] = '{6'd0, 6'd16, 6'd32, 6'd48, 6'd5, 6'd63};
    int i = 0;
    int w_full = 0;
    int w0 = a_writes;
    int cyc = 0;
    a.full = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (a.write) w_full++;
      if (i < 6) begin
        a.req_valid = 1'b1; a.req_addr = addrs[i];
        if (a.req_ready) begin exp_a.push_back(mk_pkt(addrs[i], 2'd1)); i++; end
      end else a.req_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (i !== 4) $display("FAIL burst_accepts: got %0d, expected 4", i); else n_pass++;
    n_checks++; if (a.req_ready !== 1'b0) $display("FAIL burst_ready_low: got %b, expected 0", a.req_ready); else n_pass++;
    n_checks++; if (w_full !== 0) $display("FAIL burst_write_while_full: got %0d writes, expected 0", w_full); else n_pass++;
    a.full = 1'b0;
    while ((i < 6 || exp_a.size() != 0) && cyc < 40) begin
      if (i < 6) begin
        a.req_valid = 1'b1; a.req_addr = addrs[i];
        if (a.req_ready) begin exp_a.push_back(mk_pkt(addrs[i], 2'd1)); i++; end
      end else a.req_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    a.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (cyc >= 40) $display("FAIL burst_timeout: %0d packets still pending, expected 0", exp_a.size()); else n_pass++;
    n_checks++; if (a_writes - w0 !== 6) $display("FAIL burst_delivered: got %0d, expected 6", a_writes - w0); else n_pass++;
    n_checks++; if (a.sent_cnt !== 16'd7) $display("FAIL burst_sent_cnt: got %0d, expected 7", a.sent_cnt); else n_pass++;
  endtask

  // Streams n requests, counting writes and writes that follow a write.
  task automatic stream(input int n, input logic [5:0] base, output int writes, output int b2b);
    int i = 0;
    logic prev = 1'b0;
    writes = 0; b2b = 0;
    for (int c = 0; c < 30; c++) begin
      if (a.write) begin writes++; if (prev) b2b++; end
      prev = a.write;
      if (i < n) begin
        a.req_valid = 1'b1; a.req_addr = base + 6'(i * 9);
        if (a.req_ready) begin exp_a.push_back(mk_pkt(base + 6'(i * 9), 2'd1)); i++; end
      end else a.req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int writes, b2b;
    a.almost_full = 1'b0;
    stream(6, 6'd1, writes, b2b);
    n_checks++; if (writes !== 6) $display("FAIL b2b_writes: got %0d, expected 6", writes); else n_pass++;
    n_checks++; if (b2b !== 5) $display("FAIL b2b_continuous: got %0d adjacent pairs, expected 5", b2b); else n_pass++;
  endtask

  task automatic test_almost_full();
    int writes, b2b;
    a.almost_full = 1'b1;
    stream(8, 6'd2, writes, b2b);
    a.almost_full = 1'b0;
    n_checks++; if (writes !== 8) $display("FAIL af_writes: got %0d, expected 8", writes); else n_pass++;
    n_checks++; if (b2b !== 0) $display("FAIL af_alternate: got %0d adjacent pairs, expected 0", b2b); else n_pass++;
    n_checks++; if (a.sent_cnt !== 16'd21) $display("FAIL af_sent_cnt: got %0d, expected 21", a.sent_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [5:0] addrs [3] = '{6'd3, 6'd19, 6'd35};
    int w = 0;
    a.full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a.req_valid = 1'b1; a.req_addr = addrs[i];
      exp_a.push_back(mk_pkt(addrs[i], 2'd1));
      @(negedge clk);
    end
    a.req_valid = 1'b0; a.full = 1'b0;
    @(negedge clk);
    n_checks++; if (a.write !== 1'b1) $display("FAIL rmid_write_before: got %b, expected 1", a.write); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (a.write !== 1'b0 || a.local_valid !== 1'b0)
      $display("FAIL rmid_async_outputs: write=%b local_valid=%b, expected 0/0", a.write, a.local_valid); else n_pass++;
    n_checks++; if (a.sent_cnt !== 16'd0) $display("FAIL rmid_sent_cnt: got %0d, expected 0", a.sent_cnt); else n_pass++;
    exp_a.delete();
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (a.req_ready !== 1'b1) $display("FAIL rmid_req_ready: got %b, expected 1", a.req_ready); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a.write) w++;
    end
    n_checks++; if (w !== 0) $display("FAIL rmid_stale: got %0d writes, expected 0", w); else n_pass++;
  endtask

  task automatic test_bypass();
    b.req_valid = 1'b1; b.req_addr = 6'd40;
    exp_bl.push_back(mk_pkt(6'd40, 2'd2));
    @(negedge clk);
    b.req_addr = 6'd10;
    exp_bn.push_back(mk_pkt(6'd10, 2'd2));
    @(negedge clk);
    b.req_valid = 1'b0;
    n_checks++; if (b.local_valid !== 1'b1 || b.write !== 1'b0)
      $display("FAIL byp_local_first: local_valid=%b write=%b, expected 1/0", b.local_valid, b.write); else n_pass++;
    @(negedge clk);
    n_checks++; if (b.write !== 1'b1 || b.local_valid !== 1'b0)
      $display("FAIL byp_noc_second: write=%b local_valid=%b, expected 1/0", b.write, b.local_valid); else n_pass++;
    n_checks++; if (b.sent_cnt !== 2'd1) $display("FAIL byp_sent_cnt: got %0d, expected 1", b.sent_cnt); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_bypass_block();
    int busy = 0;
    int t_w = -1;
    int t_l = -1;
    b.full = 1'b1;
    b.req_valid = 1'b1; b.req_addr = 6'd10;
    exp_bn.push_back(mk_pkt(6'd10, 2'd2));
    @(negedge clk);
    b.req_addr = 6'd40;
    exp_bl.push_back(mk_pkt(6'd40, 2'd2));
    @(negedge clk);
    b.req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (b.write || b.local_valid) busy++;
      @(negedge clk);
    end
    n_checks++; if (busy !== 0) $display("FAIL block_stall: got %0d outputs, expected 0", busy); else n_pass++;
    b.full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b.write && t_w < 0) t_w = c;
      if (b.local_valid && t_l < 0) t_l = c;
    end
    n_checks++; if (t_w < 0 || t_l < 0 || t_l <= t_w)
      $display("FAIL block_order: write at %0d local at %0d, expected write first", t_w, t_l); else n_pass++;
  endtask

  task automatic test_cnt_wrap();
    int i = 0;
    int k = 0;
    logic [1:0] want;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    b.full = 1'b0; b.almost_full = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (b.write) begin
        want = 2'((k + 1) % 4);
        n_checks++; if (b.sent_cnt !== want) $display("FAIL cnt_wrap_%0d: got %0d, expected %0d", k, b.sent_cnt, want); else n_pass++;
        k++;
      end
      if (i < 5) begin
        b.req_valid = 1'b1; b.req_addr = 6'(i);
        if (b.req_ready) begin exp_bn.push_back(mk_pkt(6'(i), 2'd2)); i++; end
      end else b.req_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (k !== 5) $display("FAIL cnt_wrap_count: got %0d packets, expected 5", k); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_almost_full();
    test_reset_mid();
    test_bypass();
    test_bypass_block();
    test_cnt_wrap();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_a.size() + exp_bn.size() + exp_bl.size() != 0)
      $display("FAIL leftover_packets: got %0d undelivered, expected 0", exp_a.size() + exp_bn.size() + exp_bl.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
